bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter_if.sv | 34 +++
 rtl/bus_rr_arbiter.sv | 118 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_if.sv
// ============================================================================
//  Module   : bus_rr_arbiter_if
//  Brief    : Requester/downstream handshake bundle for the round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_rr_arbiter_if #(
  parameter int DW = 8,
  parameter int NR = 4,
  parameter int IW = $clog2(NR)
) ();
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_vld_i;
  logic [NR-1:0]    req_last_i;
  logic [NR-1:0]    req_busy_o;
  logic [DW-1:0]    out_data_o;
  logic             out_vld_o;
  logic             out_last_o;
  logic [IW-1:0]    out_id_o;
  logic             out_busy_i;

  modport master (
    input  req_data_i, req_vld_i, req_last_i, out_busy_i,
    output req_busy_o, out_data_o, out_vld_o, out_last_o, out_id_o
  );

  modport slave (
    output req_data_i, req_vld_i, req_last_i, out_busy_i,
    input  req_busy_o, out_data_o, out_vld_o, out_last_o, out_id_o
  );
endinterface

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// ============================================================================
//  Module   : bus_rr_arbiter
//  Brief    : Packet-locked round-robin arbiter muxing NR requesters downstream.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr_arbiter #(
  parameter int DW = 8,
  parameter int NR = 4,
  parameter int IW = $clog2(NR)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  bus_rr_arbiter_if.master   bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_rr_nxt;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] w_rr_win;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_win_plus1;
  logic [IW:0]   w_idx;
  logic          w_found;
  logic          w_has_win;
  logic          w_vld;
  logic          w_last;
  logic          w_accept;

  // Rotating priority search starting at rr_ptr; sum stays below 2*NR so IW+1 bits suffice.
  always_comb begin
    w_found  = 1'b0;
    w_rr_win = '0;
    w_idx    = '0;
    for (int i = 0; i < NR; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (w_idx >= (IW+1)'(NR)) begin
        w_idx = w_idx - (IW+1)'(NR);
      end
      if (!w_found && bus.req_vld_i[w_idx[IW-1:0]]) begin
        w_found  = 1'b1;
        w_rr_win = w_idx[IW-1:0];
      end
    end
  end

  assign w_win       = (r_state == LOCKED) ? r_owner : w_rr_win;
  assign w_has_win   = !reset_i && ((r_state == LOCKED) || w_found);
  assign w_vld       = w_has_win && bus.req_vld_i[w_win];
  assign w_last      = bus.req_last_i[w_win];
  assign w_accept    = w_vld && !bus.out_busy_i;
  assign w_win_plus1 = (w_win == IW'(NR-1)) ? '0 : w_win + IW'(1);

  always_comb begin
    bus.req_busy_o = '1;
    bus.out_vld_o  = 1'b0;
    bus.out_last_o = 1'b0;
    bus.out_data_o = '0;
    bus.out_id_o   = '0;
    if (w_has_win) begin
      bus.req_busy_o[w_win] = bus.out_busy_i;
      bus.out_vld_o         = w_vld;
      bus.out_last_o        = w_last;
      bus.out_data_o        = bus.req_data_i[w_win*DW +: DW];
      bus.out_id_o          = w_win;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_vld) begin
          if (w_accept && w_last) begin
            w_rr_nxt = w_win_plus1;
          end else begin
            // Lock even when stalled so the presented beat cannot switch source.
            w_state_nxt = LOCKED;
            w_owner_nxt = w_win;
          end
        end
      end
      LOCKED: begin
        if (w_accept && w_last) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_win_plus1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
// ============================================================================
//  Module   : tb_bus_rr_arbiter
//  Brief    : Directed-vector bench for bus_rr_arbiter (NR=4 and NR=3 instances).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.DW(8), .NR(4)) if4 ();
  bus_rr_arbiter_if #(.DW(8), .NR(3)) if3 ();

  bus_rr_arbiter #(.DW(8), .NR(4)) dut4 (.clk_i(clk), .reset_i(rst4), .bus(if4.master));
  bus_rr_arbiter #(.DW(8), .NR(3)) dut3 (.clk_i(clk), .reset_i(rst3), .bus(if3.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    if4.req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    if4.req_vld_i  = 4'hF;
    if4.req_last_i = 4'hF;
    if4.out_busy_i = 1'b0;
    if3.req_data_i = {8'hB2, 8'hB1, 8'hB0};
    if3.req_vld_i  = 3'b111;
    if3.req_last_i = 3'b111;
    if3.out_busy_i = 1'b0;
    #3;
    chk("rst_vld",  32'(if4.out_vld_o),  32'h0);
    chk("rst_last", 32'(if4.out_last_o), 32'h0);
    chk("rst_data", 32'(if4.out_data_o), 32'h0);
    chk("rst_id",   32'(if4.out_id_o),   32'h0);
    chk("rst_busy", 32'(if4.req_busy_o), 32'hF);
    chk("rst3_vld", 32'(if3.out_vld_o),  32'h0);

    // Alternating requesters 1 and 3, single-beat packets
    @(negedge clk); rst4 = 1'b0; if4.req_vld_i = 4'b1010;
    #1; chk("rr_a_id", 32'(if4.out_id_o), 32'd1);
        chk("rr_a_vld", 32'(if4.out_vld_o), 32'd1);
        chk("rr_a_busy", 32'(if4.req_busy_o), 32'hD);
        chk("rr_a_data", 32'(if4.out_data_o), 32'hA1);
    @(negedge clk); #1; chk("rr_b_id", 32'(if4.out_id_o), 32'd3);
                        chk("rr_b_busy", 32'(if4.req_busy_o), 32'h7);
    @(negedge clk); #1; chk("rr_c_id", 32'(if4.out_id_o), 32'd1);
    @(negedge clk); #1; chk("rr_d_id", 32'(if4.out_id_o), 32'd3);

    // Three-beat packet from requester 0 while requester 2 waits
    @(negedge clk); if4.req_vld_i = 4'b0101; if4.req_last_i = 4'b0100;
    #1; chk("pkt_b1_id", 32'(if4.out_id_o), 32'd0);
        chk("pkt_b1_last", 32'(if4.out_last_o), 32'd0);
        chk("pkt_b1_data", 32'(if4.out_data_o), 32'hA0);
        chk("pkt_b1_busy2", 32'(if4.req_busy_o[2]), 32'd1);
    @(negedge clk); #1; chk("pkt_b2_id", 32'(if4.out_id_o), 32'd0);
                        chk("pkt_b2_busy", 32'(if4.req_busy_o), 32'hE);
    @(negedge clk); if4.req_last_i = 4'b0101;
    #1; chk("pkt_b3_id", 32'(if4.out_id_o), 32'd0);
        chk("pkt_b3_last", 32'(if4.out_last_o), 32'd1);
        chk("pkt_b3_busy2", 32'(if4.req_busy_o[2]), 32'd1);
    @(negedge clk); if4.req_vld_i = 4'b0100;
    #1; chk("pkt_next_id", 32'(if4.out_id_o), 32'd2);
        chk("pkt_next_busy", 32'(if4.req_busy_o), 32'hB);

    // Downstream stall holds requester 1 even when requester 0 arrives
    @(negedge clk); if4.req_vld_i = 4'b0010; if4.req_last_i = 4'b0010; if4.out_busy_i = 1'b1;
    #1; chk("stall1_id", 32'(if4.out_id_o), 32'd1);
        chk("stall1_vld", 32'(if4.out_vld_o), 32'd1);
        chk("stall1_busy", 32'(if4.req_busy_o), 32'hF);
    @(negedge clk); if4.req_vld_i = 4'b0011;
    #1; chk("stall2_id", 32'(if4.out_id_o), 32'd1);
        chk("stall2_busy", 32'(if4.req_busy_o), 32'hF);
    @(negedge clk); if4.out_busy_i = 1'b0;
    #1; chk("stall3_id", 32'(if4.out_id_o), 32'd1);
        chk("stall3_busy", 32'(if4.req_busy_o), 32'hD);
    @(negedge clk); if4.req_vld_i = 4'b0001; if4.req_last_i = 4'b0001;
    #1; chk("after_stall_id", 32'(if4.out_id_o), 32'd0);
        chk("after_stall_busy", 32'(if4.req_busy_o), 32'hE);

    // Owner drops valid while locked
    @(negedge clk); if4.req_vld_i = 4'b0010; if4.req_last_i = 4'b0000;
    #1; chk("drop_b1_id", 32'(if4.out_id_o), 32'd1);
    @(negedge clk); if4.req_vld_i = 4'b1001;
    #1; chk("drop_vld", 32'(if4.out_vld_o), 32'd0);
        chk("drop_busy", 32'(if4.req_busy_o), 32'hD);
    @(negedge clk); if4.req_vld_i = 4'b1011; if4.req_last_i = 4'b0010;
    #1; chk("drop_end_id", 32'(if4.out_id_o), 32'd1);
        chk("drop_end_last", 32'(if4.out_last_o), 32'd1);

    // Asynchronous reset during beat 2 of a requester-3 packet
    @(negedge clk); if4.req_vld_i = 4'b1000; if4.req_last_i = 4'b0000;
    #1; chk("ar_b1_id", 32'(if4.out_id_o), 32'd3);
    @(negedge clk); if4.req_vld_i = 4'b1001;
    #1; chk("ar_b2_id", 32'(if4.out_id_o), 32'd3);
        chk("ar_b2_data", 32'(if4.out_data_o), 32'hA3);
    #2; rst4 = 1'b1;
    #1; chk("ar_vld", 32'(if4.out_vld_o), 32'd0);
        chk("ar_busy", 32'(if4.req_busy_o), 32'hF);
        chk("ar_id", 32'(if4.out_id_o), 32'd0);
        chk("ar_data", 32'(if4.out_data_o), 32'd0);
    @(negedge clk); rst4 = 1'b0; if4.req_last_i = 4'hF;
    #1; chk("ar_post_id", 32'(if4.out_id_o), 32'd0);
        chk("ar_post_vld", 32'(if4.out_vld_o), 32'd1);
    @(negedge clk); #1; chk("ar_post2_id", 32'(if4.out_id_o), 32'd3);

    // NR=3 wrap: bring rr_ptr to 2, then all valid
    @(negedge clk); rst3 = 1'b0; if3.req_vld_i = 3'b010;
    #1; chk("nr3_pre_id", 32'(if3.out_id_o), 32'd1);
    @(negedge clk); if3.req_vld_i = 3'b111;
    #1; chk("nr3_g0", 32'(if3.out_id_o), 32'd2);
        chk("nr3_g0_busy", 32'(if3.req_busy_o), 32'h3);
    @(negedge clk); #1; chk("nr3_g1", 32'(if3.out_id_o), 32'd0);
    @(negedge clk); #1; chk("nr3_g2", 32'(if3.out_id_o), 32'd1);
    @(negedge clk); #1; chk("nr3_g3", 32'(if3.out_id_o), 32'd2);
        chk("nr3_g3_data", 32'(if3.out_data_o), 32'hB2);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
